// File: rtl/hamming_decoder_pipe.sv
// rtl/hamming_decoder_pipe.sv - two-stage (71,64) Hamming SEC decoder with valid/ready stream
// Define HAMMING_DEC_STATS_EN to add the saturating error statistics counters.
module hamming_decoder_pipe #(
`ifdef HAMMING_DEC_STATS_EN
  parameter int CNT_W  = 16,
`endif
  parameter int CW_W   = 71,
  parameter int DATA_W = 64,
  parameter int SYN_W  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW_W-1:0]   encoded_data,
  input  logic              correct_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic [SYN_W-1:0]  syndrome,
  output logic              err_corrected,
  output logic              err_uncorrectable
`ifdef HAMMING_DEC_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt
`endif
);

  // Codeword index of data bit d: the d-th index whose position (index+1) is not a power of two.
  function automatic int data_index(input int d);
    int n;
    int r;
    n = 0;
    r = 0;
    for (int i = 0; i < CW_W; i++) begin
      if ((((i + 1) & i)) != 0) begin
        if (n == d) r = i;
        n++;
      end
    end
    return r;
  endfunction

  logic [SYN_W-1:0]  in_syn;
  logic [DATA_W-1:0] in_data;
  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;
  logic [SYN_W-1:0]  s1_syn;
  logic              s1_fix;
  logic [DATA_W-1:0] fix_data;
  logic              flag_corr;
  logic              flag_unc;
  logic              adv2;
  logic              accept;

  always_comb begin
    in_syn = '0;
    for (int i = 0; i < CW_W; i++) begin
      for (int k = 0; k < SYN_W; k++) begin
        if ((((i + 1) >> k) & 1) == 1) in_syn[k] = in_syn[k] ^ encoded_data[i];
      end
    end
  end

  // Parity bits are spent once the syndrome exists, so only data bits travel down the pipe.
  for (genvar d = 0; d < DATA_W; d++) begin : g_extract
    localparam int IDX = data_index(d);
    assign in_data[d]  = encoded_data[IDX];
    assign fix_data[d] = s1_data[d] ^ (s1_fix && (s1_syn == SYN_W'(IDX + 1)));
  end

  assign flag_corr = (s1_syn != '0) && (s1_syn <= SYN_W'(CW_W));
  assign flag_unc  = (s1_syn > SYN_W'(CW_W));

  assign adv2     = s1_valid & (~out_valid | out_ready);
  assign in_ready = ~s1_valid | adv2;
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_syn   <= '0;
      s1_fix   <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_data  <= in_data;
      s1_syn   <= in_syn;
      s1_fix   <= correct_en;
    end else if (adv2) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid         <= 1'b0;
      data_out          <= '0;
      syndrome          <= '0;
      err_corrected     <= 1'b0;
      err_uncorrectable <= 1'b0;
    end else if (adv2) begin
      out_valid         <= 1'b1;
      data_out          <= fix_data;
      syndrome          <= s1_syn;
      err_corrected     <= flag_corr;
      err_uncorrectable <= flag_unc;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef HAMMING_DEC_STATS_EN
  logic out_xfer;
  assign out_xfer = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst || stats_clr) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (out_xfer) begin
      if (err_corrected && (corr_cnt != '1)) corr_cnt <= corr_cnt + CNT_W'(1);
      if (err_uncorrectable && (uncorr_cnt != '1)) uncorr_cnt <= uncorr_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hamming_decoder_pipe.sv
// tb/tb_hamming_decoder_pipe.sv - randomized/directed bench for hamming_decoder_pipe against a position-XOR model
// Build with HAMMING_DEC_STATS_EN to also cover the statistics counters.
module tb_hamming_decoder_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [70:0] encoded_data;
  logic        correct_en;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] data_out;
  logic [6:0]  syndrome;
  logic        err_corrected;
  logic        err_uncorrectable;
`ifdef HAMMING_DEC_STATS_EN
  logic        stats_clr;
  logic [15:0] corr_cnt;
  logic [15:0] uncorr_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hamming_decoder_pipe dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .encoded_data(encoded_data),
    .correct_en(correct_en),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .data_out(data_out),
    .syndrome(syndrome),
    .err_corrected(err_corrected),
    .err_uncorrectable(err_uncorrectable)
`ifdef HAMMING_DEC_STATS_EN
    ,
    .stats_clr(stats_clr),
    .corr_cnt(corr_cnt),
    .uncorr_cnt(uncorr_cnt)
`endif
  );

  function automatic bit is_pow2(input int x);
    return (x & (x - 1)) == 0;
  endfunction

  function automatic logic [70:0] encode(input logic [63:0] d);
    logic [70:0] cw;
    int n;
    int s;
    cw = '0;
    n = 0;
    for (int i = 0; i < 71; i++) begin
      if (!is_pow2(i + 1)) begin
        cw[i] = d[n];
        n++;
      end
    end
    s = 0;
    for (int i = 0; i < 71; i++) if (cw[i]) s = s ^ (i + 1);
    for (int k = 0; k < 7; k++) cw[(1 << k) - 1] = ((s >> k) & 1) == 1;
    return cw;
  endfunction

  // Syndrome is the XOR of the positions of all set bits.
  function automatic void ref_decode(input logic [70:0] cw, input bit ce, output logic [63:0] d,
                                     output int s, output bit fc, output bit fu);
    logic [70:0] c;
    int n;
    s = 0;
    for (int i = 0; i < 71; i++) if (cw[i]) s = s ^ (i + 1);
    fc = (s >= 1) && (s <= 71);
    fu = (s >= 72);
    c = cw;
    if (fc && ce) c[s - 1] = ~c[s - 1];
    d = '0;
    n = 0;
    for (int i = 0; i < 71; i++) begin
      if (!is_pow2(i + 1)) begin
        d[n] = c[i];
        n++;
      end
    end
  endfunction

  task automatic xfer(input logic [70:0] cw, input bit ce, output logic [63:0] d, output logic [6:0] s,
                      output bit fc, output bit fu, output bit timeout);
    int cnt;
    @(negedge clk);
    in_valid = 1'b1;
    encoded_data = cw;
    correct_en = ce;
    out_ready = 1'b1;
    #1;
    cnt = 0;
    while (!in_ready && cnt < 20) begin
      @(negedge clk);
      #1;
      cnt++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    while (!out_valid && cnt < 30) begin
      @(negedge clk);
      cnt++;
    end
    timeout = !out_valid;
    d = data_out;
    s = syndrome;
    fc = err_corrected;
    fu = err_uncorrectable;
  endtask

  task automatic test_reset();
    logic [63:0] v;
    rst = 1'b1;
    in_valid = 1'b1;
    encoded_data = encode(64'hDEAD_BEEF_CAFE_F00D) ^ (71'd1 << 9);
    correct_en = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || data_out !== 64'd0) begin
      errors++;
      $display("FAIL reset_out: out_valid=%b data_out=%h, required 0/0", out_valid, data_out);
    end
    checks++;
    if (syndrome !== 7'd0 || err_corrected !== 1'b0 || err_uncorrectable !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: syn=%0d fc=%b fu=%b, required 0", syndrome, err_corrected, err_uncorrectable);
    end
`ifdef HAMMING_DEC_STATS_EN
    checks++;
    if (corr_cnt !== 16'd0 || uncorr_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_cnt: corr=%0d uncorr=%0d, required 0", corr_cnt, uncorr_cnt);
    end
`endif
    v = 64'h5A5A_1234_0F0F_8888;
    rst = 1'b0;
    encoded_data = encode(v);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: %b, required 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_n1: out_valid=%b, required 0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || data_out !== v) begin
      errors++;
      $display("FAIL latency_n2: out_valid=%b data=%h, required 1/%h", out_valid, data_out, v);
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [70:0] cw;
    bit          ce;
    logic [63:0] d;
    logic [6:0]  s;
    bit          fc;
    bit          fu;
  } dcase_t;

  task automatic test_directed();
    dcase_t tc[8];
    logic [70:0] base;
    logic [63:0] d;
    logic [6:0] s;
    bit fc, fu, to;
    base = encode(64'h0123_4567_89AB_CDEF);
    tc[0] = '{71'd0, 1'b1, 64'd0, 7'd0, 1'b0, 1'b0};
    tc[1] = '{base ^ (71'd1 << 2), 1'b1, 64'h0123_4567_89AB_CDEF, 7'd3, 1'b1, 1'b0};
    tc[2] = '{base ^ (71'd1 << 2), 1'b0, 64'h0123_4567_89AB_CDEE, 7'd3, 1'b1, 1'b0};
    tc[3] = '{71'd1, 1'b1, 64'd0, 7'd1, 1'b1, 1'b0};
    tc[4] = '{71'd1 << 70, 1'b1, 64'd0, 7'd71, 1'b1, 1'b0};
    tc[5] = '{71'd1 << 70, 1'b0, 64'h8000_0000_0000_0000, 7'd71, 1'b1, 1'b0};
    tc[6] = '{(71'd1 << 70) | (71'd1 << 55), 1'b1, 64'h8002_0000_0000_0000, 7'd127, 1'b0, 1'b1};
    tc[7] = '{base, 1'b1, 64'h0123_4567_89AB_CDEF, 7'd0, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      xfer(tc[i].cw, tc[i].ce, d, s, fc, fu, to);
      checks++;
      if (to) begin
        errors++;
        $display("FAIL directed%0d_timeout: no out_valid", i);
      end
      checks++;
      if (d !== tc[i].d) begin
        errors++;
        $display("FAIL directed%0d_data: %h, required %h", i, d, tc[i].d);
      end
      checks++;
      if (s !== tc[i].s || fc !== tc[i].fc || fu !== tc[i].fu) begin
        errors++;
        $display("FAIL directed%0d_flags: syn=%0d fc=%b fu=%b, required %0d/%b/%b", i, s, fc, fu,
                 tc[i].s, tc[i].fc, tc[i].fu);
      end
    end
  endtask

  function automatic logic [70:0] corrupt(input logic [70:0] cw, input int nflip);
    int a, b;
    a = $urandom_range(0, 70);
    b = $urandom_range(0, 69);
    if (b >= a) b++;
    if (nflip >= 1) cw[a] = ~cw[a];
    if (nflip >= 2) cw[b] = ~cw[b];
    return cw;
  endfunction

  task automatic test_random();
    logic [63:0] v, d, ed;
    logic [70:0] cw;
    logic [6:0] s;
    int es;
    bit ce, fc, fu, efc, efu, to;
    for (int i = 0; i < 40; i++) begin
      v = {$urandom, $urandom};
      cw = corrupt(encode(v), $urandom_range(0, 2));
      ce = 1'($urandom_range(0, 1));
      ref_decode(cw, ce, ed, es, efc, efu);
      xfer(cw, ce, d, s, fc, fu, to);
      checks++;
      if (to || d !== ed || s !== 7'(es) || fc !== efc || fu !== efu) begin
        errors++;
        $display("FAIL random%0d: to=%b d=%h s=%0d fc=%b fu=%b, required d=%h s=%0d fc=%b fu=%b",
                 i, to, d, s, fc, fu, ed, es, efc, efu);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [70:0] cw_q[8];
    bit ce_q[8];
    logic [63:0] ed_q[8];
    int es_q[8];
    bit efc_q[8], efu_q[8];
    bit pat[4];
    int sent, recv, occ, cyc, exp_corr, exp_unc;
    bit held;
    logic [63:0] hd;
    logic [6:0] hs;
    bit hfc, hfu;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cw_q[i] = corrupt(encode({$urandom, $urandom}), i % 3);
      ce_q[i] = (i != 4);
      ref_decode(cw_q[i], ce_q[i], ed_q[i], es_q[i], efc_q[i], efu_q[i]);
    end
`ifdef HAMMING_DEC_STATS_EN
    @(negedge clk);
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
`endif
    sent = 0; recv = 0; occ = 0; cyc = 0; exp_corr = 0; exp_unc = 0;
    held = 1'b0; hd = '0; hs = '0; hfc = 1'b0; hfu = 1'b0;
    while (recv < 8 && cyc < 200) begin
      @(negedge clk);
      out_ready = pat[cyc % 4];
      if (sent < 8) begin
        in_valid = 1'b1;
        encoded_data = cw_q[sent];
        correct_en = ce_q[sent];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      checks++;
      if (in_ready !== !(occ == 2 && !out_ready)) begin
        errors++;
        $display("FAIL b2b_in_ready cyc%0d: %b, required %b (occupancy %0d)", cyc, in_ready,
                 !(occ == 2 && !out_ready), occ);
      end
      if (held) begin
        checks++;
        if (out_valid !== 1'b1 || data_out !== hd || syndrome !== hs || err_corrected !== hfc ||
            err_uncorrectable !== hfu) begin
          errors++;
          $display("FAIL b2b_hold cyc%0d: v=%b d=%h, required 1/%h", cyc, out_valid, data_out, hd);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (data_out !== ed_q[recv] || syndrome !== 7'(es_q[recv]) || err_corrected !== efc_q[recv] ||
            err_uncorrectable !== efu_q[recv]) begin
          errors++;
          $display("FAIL b2b_word%0d: d=%h s=%0d fc=%b fu=%b, required d=%h s=%0d fc=%b fu=%b", recv,
                   data_out, syndrome, err_corrected, err_uncorrectable, ed_q[recv], es_q[recv],
                   efc_q[recv], efu_q[recv]);
        end
        if (efc_q[recv]) exp_corr++;
        if (efu_q[recv]) exp_unc++;
        recv++;
        occ--;
      end
      held = out_valid && !out_ready;
      hd = data_out; hs = syndrome; hfc = err_corrected; hfu = err_uncorrectable;
      if (in_valid && in_ready) begin
        sent++;
        occ++;
      end
      cyc++;
    end
    checks++;
    if (recv != 8) begin
      errors++;
      $display("FAIL b2b_timeout: received %0d, required 8", recv);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
`ifdef HAMMING_DEC_STATS_EN
    checks++;
    if (corr_cnt !== 16'(exp_corr) || uncorr_cnt !== 16'(exp_unc)) begin
      errors++;
      $display("FAIL b2b_counters: corr=%0d uncorr=%0d, required %0d/%0d", corr_cnt, uncorr_cnt,
               exp_corr, exp_unc);
    end
`endif
  endtask

`ifdef HAMMING_DEC_STATS_EN
  task automatic test_stats_clr();
    int cnt;
    logic [63:0] d;
    logic [6:0] s;
    bit fc, fu, to;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1;
    encoded_data = encode(64'h1111_2222_3333_4444) ^ (71'd1 << 5);
    correct_en = 1'b1;
    #1;
    cnt = 0;
    while (!in_ready && cnt < 20) begin
      @(negedge clk);
      #1;
      cnt++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    while (!out_valid && cnt < 30) begin
      @(negedge clk);
      cnt++;
    end
    checks++;
    if (!out_valid || !err_corrected) begin
      errors++;
      $display("FAIL clr_setup: out_valid=%b fc=%b, required 1/1", out_valid, err_corrected);
    end
    stats_clr = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    stats_clr = 1'b0;
    checks++;
    if (corr_cnt !== 16'd0 || uncorr_cnt !== 16'd0) begin
      errors++;
      $display("FAIL clr_priority: corr=%0d uncorr=%0d, required 0/0", corr_cnt, uncorr_cnt);
    end
    xfer((71'd1 << 70) | (71'd1 << 55), 1'b1, d, s, fc, fu, to);
    xfer(71'd1 << 3, 1'b1, d, s, fc, fu, to);
    @(posedge clk);
    #1;
    checks++;
    if (corr_cnt !== 16'd1 || uncorr_cnt !== 16'd1) begin
      errors++;
      $display("FAIL clr_after: corr=%0d uncorr=%0d, required 1/1", corr_cnt, uncorr_cnt);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    encoded_data = '0;
    correct_en = 1'b0;
    out_ready = 1'b0;
`ifdef HAMMING_DEC_STATS_EN
    stats_clr = 1'b0;
`endif
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
`ifdef HAMMING_DEC_STATS_EN
    test_stats_clr();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hamming_decoder_pipe.md
Name: hamming_decoder_pipe

Overview:
- Pipelined single-error-correcting decoder for the 71-bit Hamming codeword format used by the team's 64-bit Hamming encoder.
- Computes the 7-bit syndrome, corrects any single-bit error, extracts the 64 data bits, and flags errors.
- Sits on the receive side of the link or memory read path.
- Uses a valid/ready stream on both sides with full backpressure, two register stages, and throughput of 1 word/cycle.

Parameters:
- CW_W, 71, codeword width (fixed by the code format; not to be overridden)
- DATA_W, 64, decoded data width
- SYN_W, 7, syndrome width
- CNT_W, 16, width of the error statistics counters (optional feature only)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  codeword valid
- in_ready  output  1  decoder accepts codeword this cycle
- encoded_data  input  71  received codeword; bit i = code position i+1
- correct_en  input  1  1 = apply correction; 0 = pass data bits through uncorrected (flags still computed); sampled with the codeword
- out_valid  output  1  decoded word valid
- out_ready  input  1  downstream accepts word
- data_out  output  64  decoded data
- syndrome  output  7  syndrome of the word in data_out
- err_corrected  output  1  single error detected (and fixed if correct_en)
- err_uncorrectable  output  1  syndrome points outside 1..71
- stats_clr  input  1  clear error counters (optional feature only)
- corr_cnt  output  CNT_W  corrected-error count (optional feature only)
- uncorr_cnt  output  CNT_W  uncorrectable count (optional feature only)

Behaviour:
- Reset: synchronous, active-high, dominant over all other inputs. On reset, all valids clear and all outputs go to 0. Any in-flight words are discarded.
- Code layout:
  - Parity sits at indices 0, 1, 3, 7, 15, 31, 63 (positions 1, 2, 4, ..., 64).
  - Data occupies the remaining indices in ascending order: data bit 0 at index 2, bit 63 at index 70.
- Syndrome: s[k] = XOR of encoded_data[i] over all i with bit k of (i+1) set, for k = 0..6.
- Stage 1: registers the codeword, correct_en, and syndrome (s1_valid).
- Stage 2: registers the corrected/extracted data and flags (out_valid).
- Syndrome classification:
  - S = 0: no error; data extracted directly; both flags 0.
  - 1 <= S <= 71: err_corrected = 1. If correct_en, invert codeword index S-1 before extraction. If S is a parity position, data is unchanged.
  - 72 <= S <= 127: err_uncorrectable = 1. Data is extracted uncorrected.
- No double-error detection. Double errors that alias into 1..71 are miscorrected; this is accepted behaviour.
- Handshake:
  - adv2 = s1_valid & (~out_valid | out_ready).
  - in_ready = ~s1_valid | adv2 (combinational).
  - A transfer occurs when valid & ready are both high.
  - Outputs hold stable while out_valid=1 and out_ready=0.
- Latency:
  - Accept at cycle N → out_valid at N+2 when not stalled.
  - Sustained 1 word/cycle with out_ready held high.
- Simultaneous accept and drain at both stages in the same cycle is legal and loses no data.
- Stall: with out_ready=0, at most 2 words are held, then in_ready drops. Order is preserved.
- Flags and syndrome are qualified by out_valid only.

Optional Feature:
- Macro: HAMMING_DEC_STATS_EN.
- When defined:
  - corr_cnt and uncorr_cnt increment on each output transfer (out_valid & out_ready) carrying the respective flag.
  - Counters saturate at 2^CNT_W-1.
  - stats_clr (synchronous) zeroes both counters and takes priority over a same-cycle increment.
  - rst zeroes both counters.
- When undefined: stats_clr, corr_cnt, and uncorr_cnt ports are absent and no counter logic is generated.

Test Plan:
- Reset with in_valid=1 → out_valid=0, data_out=0, flags=0, counters=0. First accept after reset releases yields out_valid two cycles later.
- All-zero codeword → data_out=0, syndrome=0, both flags 0.
- Encode 64'h0123_4567_89AB_CDEF, flip index 2, correct_en=1 → syndrome=3, err_corrected=1, data_out=64'h0123_4567_89AB_CDEF. Same stimulus with correct_en=0 → data_out bit 0 inverted, i.e. 64'h0123_4567_89AB_CDEE.
- Zero codeword with index 0 flipped → syndrome=1, err_corrected=1, data_out=0. With index 70 flipped → syndrome=71, data_out=64'h8000_0000_0000_0000 corrected to 0.
- Zero codeword with indices 70 and 55 flipped → syndrome=127, err_uncorrectable=1, err_corrected=0, data bits 63 and 49 set (64'h8002_0000_0000_0000).
- Back-to-back 8 words with out_ready toggling 1,0,0,1 → in_ready low only while both stages are full. All 8 words emerge in order, unchanged while stalled. With HAMMING_DEC_STATS_EN, counters match the injected error counts exactly, and stats_clr plus a same-cycle error leaves the counter at 0.
